// File: rtl/example_reg_initiator_if.sv
// example_reg_initiator_if: command, response and register-bus signals of the initiator
interface example_reg_initiator_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_status;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_ack, bus_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status, bus_req, bus_we, bus_addr, bus_wdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_ack, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/example_reg_initiator.sv
// example_reg_initiator: runs register commands as req/ack bus transactions; EXAMPLE_REG_INITIATOR_VERIFY_EN adds write readback-verify
module example_reg_initiator #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 9,
  parameter int TIMEOUT    = 15
) (
  input logic clk,
  input logic rst,
  example_reg_initiator_if.master io
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, RESP
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
    , VERIFY
`endif
  } state_t;
  localparam logic [ADDR_WIDTH-1:0] L_NREGS = ADDR_WIDTH'(NUM_REGS);
  localparam logic [7:0]            L_TLAST = 8'(TIMEOUT - 1);
  state_t                r_state, w_state;
  logic                  r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic [1:0]            r_status, w_status;
  logic [7:0]            r_cnt, w_cnt;
  logic                  w_tout;
  logic                  w_req;
  assign w_tout = r_cnt == L_TLAST;
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
  logic r_gap, w_gap;
  assign w_req = (r_state == ISSUE) | ((r_state == VERIFY) & ~r_gap);
`else
  assign w_req = r_state == ISSUE;
`endif
  assign io.cmd_ready  = r_state == IDLE;
  assign io.rsp_valid  = r_state == RESP;
  assign io.rsp_rdata  = r_rdata;
  assign io.rsp_status = r_status;
  assign io.bus_req    = w_req;
  assign io.bus_we     = r_we & (r_state == ISSUE);
  assign io.bus_addr   = r_addr;
  assign io.bus_wdata  = r_wdata;
  // next-state and response/latch datapath; VERIFY spends its first cycle idle before the readback req
  always_comb begin
    w_state  = r_state;
    w_we     = r_we;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdata  = r_rdata;
    w_status = r_status;
    w_cnt    = r_cnt;
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
    w_gap    = 1'b0;
`endif
    case (r_state)
      IDLE: if (io.cmd_valid) begin
        w_we     = io.cmd_write;
        w_addr   = io.cmd_addr;
        w_wdata  = io.cmd_wdata;
        w_rdata  = '0;
        w_cnt    = '0;
        w_status = io.cmd_addr >= L_NREGS ? 2'b01 : 2'b00;
        w_state  = io.cmd_addr >= L_NREGS ? RESP : ISSUE;
      end
      ISSUE: if (io.bus_ack) begin
        w_status = 2'b00;
        w_rdata  = r_we ? '0 : io.bus_rdata;
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
        w_state  = r_we ? VERIFY : RESP;
        w_cnt    = '0;
        w_gap    = r_we;
`else
        w_state  = RESP;
`endif
      end else if (w_tout) begin
        w_state  = RESP;
        w_status = 2'b10;
        w_rdata  = '0;
      end else w_cnt = r_cnt + 8'd1;
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
      VERIFY: if (!r_gap) begin
        if (io.bus_ack) begin
          w_state  = RESP;
          w_rdata  = io.bus_rdata;
          w_status = io.bus_rdata == r_wdata ? 2'b00 : 2'b11;
        end else if (w_tout) begin
          w_state  = RESP;
          w_status = 2'b10;
          w_rdata  = '0;
        end else w_cnt = r_cnt + 8'd1;
      end
`endif
      RESP: if (io.rsp_ready) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state;
  // latched command, response and timeout counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_status <= 2'b00;
      r_cnt    <= '0;
    end else begin
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdata  <= w_rdata;
      r_status <= w_status;
      r_cnt    <= w_cnt;
    end
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
  // one-cycle idle marker at VERIFY entry
  always_ff @(posedge clk or posedge rst)
    if (rst) r_gap <= 1'b0;
    else r_gap <= w_gap;
`endif
endmodule

// File: tb/tb_example_reg_initiator.sv
// tb_example_reg_initiator: directed self-checking bench for example_reg_initiator
module tb_example_reg_initiator;
  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;
  example_reg_initiator_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bif ();
  example_reg_initiator #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(9), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .io (bif.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input logic w, input logic [3:0] a, input logic [31:0] d);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = w;
    bif.cmd_addr  = a;
    bif.cmd_wdata = d;
    step();
    bif.cmd_valid = 1'b0;
  endtask
  task automatic rsp_hs;
    bif.rsp_ready = 1'b1;
    step();
    bif.rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0h exp 1", bif.cmd_ready); end
    checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", bif.rsp_valid); end
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %0h exp 0", bif.bus_req); end
    checks++; if (bif.bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %0h exp 0", bif.bus_we); end
    checks++; if (bif.bus_addr !== 4'h0) begin errors++; $display("FAIL reset_bus_addr got %0h exp 0", bif.bus_addr); end
    checks++; if (bif.bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata got %0h exp 0", bif.bus_wdata); end
    checks++; if (bif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %0h exp 0", bif.rsp_rdata); end
    checks++; if (bif.rsp_status !== 2'b00) begin errors++; $display("FAIL reset_rsp_status got %0h exp 0", bif.rsp_status); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_read;
    int req_cycles = 0;
    send_cmd(1'b0, 4'd1, 32'h0);
    checks++; if (bif.bus_req !== 1'b1) begin errors++; $display("FAIL read_req got %0h exp 1", bif.bus_req); end
    checks++; if (bif.bus_we !== 1'b0) begin errors++; $display("FAIL read_we got %0h exp 0", bif.bus_we); end
    checks++; if (bif.bus_addr !== 4'd1) begin errors++; $display("FAIL read_addr got %0h exp 1", bif.bus_addr); end
    checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL read_early_valid got %0h exp 0", bif.rsp_valid); end
    checks++; if (bif.cmd_ready !== 1'b0) begin errors++; $display("FAIL read_busy_ready got %0h exp 0", bif.cmd_ready); end
    if (bif.bus_req) req_cycles++;
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h0000_0001;
    step();
    bif.bus_ack = 1'b0;
    bif.bus_rdata = 32'hDEAD_BEEF;
    if (bif.bus_req) req_cycles++;
    checks++; if (req_cycles !== 1) begin errors++; $display("FAIL read_req_cycles got %0d exp 1", req_cycles); end
    checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL read_valid got %0h exp 1", bif.rsp_valid); end
    checks++; if (bif.rsp_rdata !== 32'h1) begin errors++; $display("FAIL read_rdata got %0h exp 1", bif.rsp_rdata); end
    checks++; if (bif.rsp_status !== 2'b00) begin errors++; $display("FAIL read_status got %0h exp 0", bif.rsp_status); end
    rsp_hs();
    checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL read_hs_valid got %0h exp 0", bif.rsp_valid); end
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL read_hs_ready got %0h exp 1", bif.cmd_ready); end
  endtask
  task automatic test_write;
    send_cmd(1'b1, 4'd4, 32'h0000_000C);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bif.bus_req !== 1'b1) begin errors++; $display("FAIL write_req[%0d] got %0h exp 1", i, bif.bus_req); end
      checks++; if (bif.bus_we !== 1'b1) begin errors++; $display("FAIL write_we[%0d] got %0h exp 1", i, bif.bus_we); end
      checks++; if (bif.bus_addr !== 4'd4) begin errors++; $display("FAIL write_addr[%0d] got %0h exp 4", i, bif.bus_addr); end
      checks++; if (bif.bus_wdata !== 32'hC) begin errors++; $display("FAIL write_wdata[%0d] got %0h exp c", i, bif.bus_wdata); end
      bif.bus_ack = (i == 2);
      bif.bus_rdata = 32'h1234_5678;
      step();
    end
    bif.bus_ack = 1'b0;
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL write_req_drop got %0h exp 0", bif.bus_req); end
    checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL write_valid got %0h exp 1", bif.rsp_valid); end
    checks++; if (bif.rsp_status !== 2'b00) begin errors++; $display("FAIL write_status got %0h exp 0", bif.rsp_status); end
    checks++; if (bif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata got %0h exp 0", bif.rsp_rdata); end
    rsp_hs();
  endtask
  task automatic test_bad_addr;
    send_cmd(1'b0, 4'd9, 32'h0);
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL bad_req got %0h exp 0", bif.bus_req); end
    checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL bad_valid got %0h exp 1", bif.rsp_valid); end
    checks++; if (bif.rsp_status !== 2'b01) begin errors++; $display("FAIL bad_status got %0h exp 1", bif.rsp_status); end
    checks++; if (bif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL bad_rdata got %0h exp 0", bif.rsp_rdata); end
    rsp_hs();
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL bad_hs_ready got %0h exp 1", bif.cmd_ready); end
  endtask
  task automatic test_timeout;
    int n = 0;
    send_cmd(1'b0, 4'd2, 32'h0);
    while (bif.bus_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL tout_req_cycles got %0d exp 15", n); end
    checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL tout_valid got %0h exp 1", bif.rsp_valid); end
    checks++; if (bif.rsp_status !== 2'b10) begin errors++; $display("FAIL tout_status got %0h exp 2", bif.rsp_status); end
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h7777_7777;
    step();
    bif.bus_ack = 1'b0;
    checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL tout_late_valid got %0h exp 1", bif.rsp_valid); end
    checks++; if (bif.rsp_status !== 2'b10) begin errors++; $display("FAIL tout_late_status got %0h exp 2", bif.rsp_status); end
    checks++; if (bif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL tout_late_rdata got %0h exp 0", bif.rsp_rdata); end
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL tout_late_req got %0h exp 0", bif.bus_req); end
    rsp_hs();
  endtask
  task automatic test_reset_mid;
    send_cmd(1'b0, 4'd3, 32'h0);
    checks++; if (bif.bus_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %0h exp 1", bif.bus_req); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL rmid_req_drop got %0h exp 0", bif.bus_req); end
    checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0h exp 0", bif.rsp_valid); end
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0h exp 1", bif.cmd_ready); end
    step();
    rst = 1'b0;
    step();
    checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got %0h exp 0", bif.rsp_valid); end
    send_cmd(1'b0, 4'd5, 32'h0);
    checks++; if (bif.bus_addr !== 4'd5) begin errors++; $display("FAIL rmid_addr got %0h exp 5", bif.bus_addr); end
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h0000_0055;
    step();
    bif.bus_ack = 1'b0;
    bif.bus_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0h exp 1", i, bif.rsp_valid); end
      checks++; if (bif.rsp_rdata !== 32'h55) begin errors++; $display("FAIL hold_rdata[%0d] got %0h exp 55", i, bif.rsp_rdata); end
      checks++; if (bif.rsp_status !== 2'b00) begin errors++; $display("FAIL hold_status[%0d] got %0h exp 0", i, bif.rsp_status); end
      step();
    end
    rsp_hs();
    checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_hs_valid got %0h exp 0", bif.rsp_valid); end
  endtask
  task automatic test_back_to_back;
    send_cmd(1'b0, 4'd8, 32'h0);
    checks++; if (bif.bus_req !== 1'b1) begin errors++; $display("FAIL b2b_req8 got %0h exp 1", bif.bus_req); end
    checks++; if (bif.bus_addr !== 4'd8) begin errors++; $display("FAIL b2b_addr8 got %0h exp 8", bif.bus_addr); end
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'hA5A5_0008;
    step();
    bif.bus_ack = 1'b0;
    checks++; if (bif.rsp_rdata !== 32'hA5A5_0008) begin errors++; $display("FAIL b2b_rdata8 got %0h exp a5a50008", bif.rsp_rdata); end
    rsp_hs();
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0h exp 1", bif.cmd_ready); end
    send_cmd(1'b0, 4'd15, 32'h0);
    checks++; if (bif.rsp_status !== 2'b01) begin errors++; $display("FAIL b2b_status15 got %0h exp 1", bif.rsp_status); end
    checks++; if (bif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rdata15 got %0h exp 0", bif.rsp_rdata); end
    rsp_hs();
  endtask
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
  task automatic test_verify;
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic [1:0]  st [2];
    wd[0] = 32'hFFFF_FFFF; rd[0] = 32'h0000_003F; st[0] = 2'b11;
    wd[1] = 32'h0000_0015; rd[1] = 32'h0000_0015; st[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      send_cmd(1'b1, 4'd2, wd[i]);
      checks++; if (bif.bus_we !== 1'b1) begin errors++; $display("FAIL ver_we[%0d] got %0h exp 1", i, bif.bus_we); end
      bif.bus_ack = 1'b1;
      step();
      bif.bus_ack = 1'b0;
      checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL ver_gap[%0d] got %0h exp 0", i, bif.bus_req); end
      checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL ver_gap_valid[%0d] got %0h exp 0", i, bif.rsp_valid); end
      step();
      checks++; if (bif.bus_req !== 1'b1) begin errors++; $display("FAIL ver_rreq[%0d] got %0h exp 1", i, bif.bus_req); end
      checks++; if (bif.bus_we !== 1'b0) begin errors++; $display("FAIL ver_rwe[%0d] got %0h exp 0", i, bif.bus_we); end
      checks++; if (bif.bus_addr !== 4'd2) begin errors++; $display("FAIL ver_raddr[%0d] got %0h exp 2", i, bif.bus_addr); end
      bif.bus_ack = 1'b1;
      bif.bus_rdata = rd[i];
      step();
      bif.bus_ack = 1'b0;
      checks++; if (bif.rsp_valid !== 1'b1) begin errors++; $display("FAIL ver_valid[%0d] got %0h exp 1", i, bif.rsp_valid); end
      checks++; if (bif.rsp_status !== st[i]) begin errors++; $display("FAIL ver_status[%0d] got %0h exp %0h", i, bif.rsp_status, st[i]); end
      checks++; if (bif.rsp_rdata !== rd[i]) begin errors++; $display("FAIL ver_rdata[%0d] got %0h exp %0h", i, bif.rsp_rdata, rd[i]); end
      rsp_hs();
    end
  endtask
`endif
  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_wdata = '0;
    bif.rsp_ready = 1'b0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    test_reset();
    test_read();
`ifdef EXAMPLE_REG_INITIATOR_VERIFY_EN
    test_verify();
`else
    test_write();
`endif
    test_bad_addr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
